// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request and a small FIFO of
// {instruction, pc} entries toward decode. Redirects flush the FIFO and steer fetchPc.
module fetch_queue #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectPc,
    output logic                  reqI,
    output logic [ADDR_WIDTH-1:0] memIAddr,
    input  logic                  memIReady,
    input  logic [DATA_WIDTH-1:0] memIData,
    output logic                  instrValid,
    output logic [DATA_WIDTH-1:0] instrOut,
    output logic [ADDR_WIDTH-1:0] instrPc,
    input  logic                  instrReady
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      count_after_push;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    assign pc_plus4         = fetch_pc_q + ADDR_WIDTH'(4);
    assign pop              = (count_q != '0) && instrReady && !redirect;
    assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        reqI       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!redirect && (count_q < DEPTH_CNT)) begin
                    state_d    = StWait;
                    req_addr_d = fetch_pc_q;
                end
            end
            StWait: begin
                reqI = 1'b1;
                if (redirect) begin
                    state_d = memIReady ? StIdle : StDrop;
                end else if (memIReady) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus4;
                    if (count_after_push < DEPTH_CNT) begin
                        req_addr_d = pc_plus4;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                // Stale response from before the redirect; swallow it and restart.
                reqI = 1'b1;
                if (memIReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect) begin
            fetch_pc_d = redirectPc & ~ADDR_WIDTH'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= memIData;
            pc_mem[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign memIAddr   = req_addr_q;
    assign instrValid = (count_q != '0);
    assign instrOut   = instrValid ? data_mem[rd_ptr_q] : '0;
    assign instrPc    = instrValid ? pc_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue: each vector gives the inputs for one cycle
// and the outputs expected during that cycle, before the next rising edge.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        reqI;
    logic [31:0] memIAddr;
    logic        memIReady;
    logic [31:0] memIData;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        instrReady;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        mrdy;
        logic [31:0] mdata;
        logic        irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_out;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    fetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .reqI       (reqI),
        .memIAddr   (memIAddr),
        .memIReady  (memIReady),
        .memIData   (memIData),
        .instrValid (instrValid),
        .instrOut   (instrOut),
        .instrPc    (instrPc),
        .instrReady (instrReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rd, logic [31:0] rpc, logic mr, logic [31:0] md,
                                logic ir, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] eo, logic [31:0] ep);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.mrdy = mr; v.mdata = md; v.irdy = ir;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_out = eo; v.e_pc = ep;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, vec_t v);
        check({tag, " reqI"}, 32'(reqI), 32'(v.e_req));
        check({tag, " memIAddr"}, memIAddr, v.e_addr);
        check({tag, " instrValid"}, 32'(instrValid), 32'(v.e_valid));
        check({tag, " instrOut"}, instrOut, v.e_out);
        check({tag, " instrPc"}, instrPc, v.e_pc);
    endtask

    // Drive one cycle's inputs at the falling edge and check outputs shortly after.
    task automatic apply(string tag, vec_t v);
        @(negedge clk);
        redirect   = v.rd;
        redirectPc = v.rpc;
        memIReady  = v.mrdy;
        memIData   = v.mdata;
        instrReady = v.irdy;
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        reset      = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        memIReady  = 1'b0;
        memIData   = '0;
        instrReady = 1'b0;

        //           rd rpc           mr md            ir  req addr          v  out           pc
        // back-to-back fetch with decode always ready; memIReady in IDLE ignored
        tbl.push_back(mk(0, 0,            1, 32'hDEAD0000, 1, 0, 32'h0,        0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hA0A0A000, 1, 1, 32'h0,        0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hA0A0A004, 1, 1, 32'h4,        1, 32'hA0A0A000, 32'h0));
        tbl.push_back(mk(0, 0,            0, 0,            1, 1, 32'h8,        1, 32'hA0A0A004, 32'h4));
        // decode stalled: two pushes fill the buffer, then IDLE
        tbl.push_back(mk(0, 0,            1, 32'hA0A0A008, 0, 1, 32'h8,        0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hA0A0A00C, 0, 1, 32'hC,        1, 32'hA0A0A008, 32'h8));
        tbl.push_back(mk(0, 0,            1, 32'hDEAD0001, 0, 0, 32'hC,        1, 32'hA0A0A008, 32'h8));
        tbl.push_back(mk(0, 0,            0, 0,            1, 0, 32'hC,        1, 32'hA0A0A008, 32'h8));
        tbl.push_back(mk(0, 0,            0, 0,            0, 0, 32'hC,        1, 32'hA0A0A00C, 32'hC));
        tbl.push_back(mk(0, 0,            0, 0,            1, 1, 32'h10,       1, 32'hA0A0A00C, 32'hC));
        // redirect while waiting, response arrives two cycles later and is dropped
        tbl.push_back(mk(1, 32'h100,      0, 0,            1, 1, 32'h10,       0, 0,            0));
        tbl.push_back(mk(0, 0,            0, 0,            1, 1, 32'h10,       0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hBAD0BAD0, 1, 1, 32'h10,       0, 0,            0));
        tbl.push_back(mk(0, 0,            0, 0,            1, 0, 32'h10,       0, 0,            0));
        // redirect coincident with a response, unaligned target
        tbl.push_back(mk(1, 32'h203,      1, 32'hBAD1BAD1, 1, 1, 32'h100,      0, 0,            0));
        tbl.push_back(mk(0, 0,            0, 0,            1, 0, 32'h100,      0, 0,            0));
        // redirect to the top of the address space, then wrap
        tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0,            1, 1, 32'h200,      0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hBAD2BAD2, 1, 1, 32'h200,      0, 0,            0));
        tbl.push_back(mk(0, 0,            0, 0,            1, 0, 32'h200,      0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hC0C0C000, 1, 1, 32'hFFFFFFFC, 0, 0,            0));
        tbl.push_back(mk(0, 0,            1, 32'hC0C0C001, 1, 1, 32'h0,        1, 32'hC0C0C000, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 0,            0, 0,            1, 1, 32'h4,        1, 32'hC0C0C001, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));

        @(posedge clk);
        #2 reset = 1'b1;
        foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

        // Reset mid-request with a non-empty buffer: outputs clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        check_outs("async_reset", mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        @(posedge clk);
        #2 reset = 1'b1;

        // late response right after release is ignored; first request at RESET_PC
        apply("r0", mk(0, 0,       1, 32'hDEAD0002, 0, 0, 32'h0,  0, 0,            0));
        apply("r1", mk(0, 0,       0, 0,            0, 1, 32'h0,  0, 0,            0));
        apply("r2", mk(0, 0,       1, 32'hE0E0E000, 0, 1, 32'h0,  0, 0,            0));
        // redirect flushes a non-empty buffer
        apply("r3", mk(1, 32'h40,  0, 0,            0, 1, 32'h4,  1, 32'hE0E0E000, 32'h0));
        apply("r4", mk(0, 0,       0, 0,            0, 1, 32'h4,  0, 0,            0));
        apply("r5", mk(0, 0,       1, 32'hBAD3BAD3, 0, 1, 32'h4,  0, 0,            0));
        apply("r6", mk(0, 0,       0, 0,            0, 0, 32'h4,  0, 0,            0));
        apply("r7", mk(0, 0,       1, 32'hF0F0F040, 0, 1, 32'h40, 0, 0,            0));
        apply("r8", mk(0, 0,       1, 32'hF0F0F044, 0, 1, 32'h44, 1, 32'hF0F0F040, 32'h40));
        // redirect while IDLE with a full buffer
        apply("r9", mk(1, 32'h80,  0, 0,            0, 0, 32'h44, 1, 32'hF0F0F040, 32'h40));
        apply("r10", mk(0, 0,      0, 0,            0, 0, 32'h44, 0, 0,            0));
        apply("r11", mk(0, 0,      0, 0,            0, 1, 32'h80, 0, 0,            0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
